sid_bus_responder: RTL and testbench



---
 rtl/sid_bus_pkg.sv | 36 +++
 rtl/sid_bus_sync.sv | 38 +++
 rtl/sid_bus_responder.sv | 162 ++++++++++++++++
 tb/tb_sid_bus_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sid_bus_pkg.sv
// rtl/sid_bus_pkg.sv - SID register map, bus field layout and responder FSM states
package sid_bus_pkg;

    localparam logic [4:0] ADDR_V1_BASE  = 5'h00;
    localparam logic [4:0] ADDR_V2_BASE  = 5'h07;
    localparam logic [4:0] ADDR_V3_BASE  = 5'h0E;
    localparam logic [4:0] ADDR_FC_LO    = 5'h15;
    localparam logic [4:0] ADDR_FC_HI    = 5'h16;
    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
    localparam logic [4:0] ADDR_POTX     = 5'h19;
    localparam logic [4:0] ADDR_POTY     = 5'h1A;
    localparam logic [4:0] ADDR_OSC3     = 5'h1B;
    localparam logic [4:0] ADDR_ENV3     = 5'h1C;
    localparam logic [4:0] LAST_WR_REG   = 5'h18;

    localparam int BUS_FIELDS_W = 15;

    typedef struct packed {
        logic       cs_n;
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
    } bus_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_READ = 2'd2
    } bus_state_t;

    function automatic logic is_wr_reg(input logic [4:0] addr);
        return addr <= LAST_WR_REG;
    endfunction

endpackage

// File: rtl/sid_bus_sync.sv
// rtl/sid_bus_sync.sv - multi-bit bus synchronizer with phi2 rise/fall pulse generation
module sid_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_phi2,
    input  logic [W-1:0] i_bus,
    output logic         o_phi2,
    output logic [W-1:0] o_bus,
    output logic         o_rise,
    output logic         o_fall
);

    // phi2 travels in the same chain as the bus fields so all stay cycle-aligned.
    logic [SYNC_STAGES-1:0][W:0] r_stage;
    logic                        r_phi2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage  <= '0;
            r_phi2_d <= 1'b0;
        end else begin
            r_stage[0] <= {i_phi2, i_bus};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_phi2_d <= r_stage[SYNC_STAGES-1][W];
        end
    end

    assign o_phi2 = r_stage[SYNC_STAGES-1][W];
    assign o_bus  = r_stage[SYNC_STAGES-1][W-1:0];
    assign o_rise = o_phi2 & ~r_phi2_d;
    assign o_fall = ~o_phi2 & r_phi2_d;

endmodule

// File: rtl/sid_bus_responder.sv
// rtl/sid_bus_responder.sv - device side of the SID bus: write strobes, register reads, decaying bus latch
module sid_bus_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int DECAY_CYCLES = 2000,
    parameter int DECAY_W      = 11
) (
    input  logic       dcm_clk,
    input  logic       sid_notres,
    input  logic       sid_clk,
    input  logic       sid_notcs,
    input  logic       sid_rw,
    input  logic [4:0] sid_addr,
    input  logic [7:0] sid_data_in,
    input  logic [7:0] pot_x,
    input  logic [7:0] pot_y,
    input  logic [7:0] osc3,
    input  logic [7:0] env3,
    output logic [7:0] sid_data_out,
    output logic       sid_data_oe,
    output logic       reg_wr_stb,
    output logic [4:0] reg_wr_addr,
    output logic [7:0] reg_wr_data
);

    import sid_bus_pkg::*;

    logic              w_phi2;
    logic              w_rise;
    logic              w_fall;
    bus_fields_t       w_sync_bus;
    bus_fields_t       r_cap;
    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic              w_do_read;
    logic              w_do_write;
    logic [7:0]        w_rd_mux;
    logic [7:0]        r_latch;
    logic [DECAY_W-1:0] r_decay;
    logic [7:0]        r_data_out;
    logic              r_data_oe;
    logic              r_wr_stb;
    logic [4:0]        r_wr_addr;
    logic [7:0]        r_wr_data;

    sid_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .W          (BUS_FIELDS_W)
    ) u_sync (
        .clk   (dcm_clk),
        .rst_n (sid_notres),
        .i_phi2(sid_clk),
        .i_bus ({sid_notcs, sid_rw, sid_addr, sid_data_in}),
        .o_phi2(w_phi2),
        .o_bus (w_sync_bus),
        .o_rise(w_rise),
        .o_fall(w_fall)
    );

    // Capture tracks the bus while phi2 is high, so at the fall it holds the last high-phase values.
    always_ff @(posedge dcm_clk or negedge sid_notres) begin
        if (!sid_notres) begin
            r_cap      <= '0;
            r_cap.cs_n <= 1'b1;
        end else if (w_phi2) begin
            r_cap <= w_sync_bus;
        end
    end

    always_comb begin
        case (w_sync_bus.addr)
            ADDR_POTX: w_rd_mux = pot_x;
            ADDR_POTY: w_rd_mux = pot_y;
            ADDR_OSC3: w_rd_mux = osc3;
            ADDR_ENV3: w_rd_mux = env3;
            default:   w_rd_mux = r_latch;
        endcase
    end

    always_ff @(posedge dcm_clk or negedge sid_notres) begin
        if (!sid_notres) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_read   = 1'b0;
        w_do_write  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (!w_sync_bus.cs_n && w_sync_bus.rw) begin
                        w_do_read   = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_state_nxt = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_do_write  = !r_cap.cs_n && !r_cap.rw;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge dcm_clk or negedge sid_notres) begin
        if (!sid_notres) begin
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else if (w_do_read) begin
            r_data_out <= w_rd_mux;
            r_data_oe  <= 1'b1;
        end else if (r_state == ST_READ && w_fall) begin
            r_data_oe  <= 1'b0;
        end
    end

    // A write on the expiring fall takes priority over the decay clear.
    always_ff @(posedge dcm_clk or negedge sid_notres) begin
        if (!sid_notres) begin
            r_latch   <= 8'h00;
            r_decay   <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 5'h00;
            r_wr_data <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_do_write) begin
                r_latch <= r_cap.data;
                r_decay <= DECAY_CYCLES[DECAY_W-1:0];
                if (is_wr_reg(r_cap.addr)) begin
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_cap.addr;
                    r_wr_data <= r_cap.data;
                end
            end else if (w_fall && r_decay != '0) begin
                r_decay <= r_decay - DECAY_W'(1);
                if (r_decay == DECAY_W'(1)) begin
                    r_latch <= 8'h00;
                end
            end
        end
    end

    assign sid_data_out = r_data_out;
    assign sid_data_oe  = r_data_oe;
    assign reg_wr_stb   = r_wr_stb;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;

endmodule

// File: tb/tb_sid_bus_responder.sv
// tb/tb_sid_bus_responder.sv - directed bench for sid_bus_responder with short decay
module tb_sid_bus_responder;

    localparam int LOW_A = 64;
    localparam int HIGH  = 128;
    localparam int LOW_B = 64;

    logic       dcm_clk     = 1'b0;
    logic       sid_notres  = 1'b0;
    logic       sid_clk     = 1'b0;
    logic       sid_notcs   = 1'b1;
    logic       sid_rw      = 1'b1;
    logic [4:0] sid_addr    = 5'h00;
    logic [7:0] sid_data_in = 8'h00;
    logic [7:0] pot_x       = 8'h11;
    logic [7:0] pot_y       = 8'h22;
    logic [7:0] osc3        = 8'h00;
    logic [7:0] env3        = 8'h44;
    logic [7:0] sid_data_out;
    logic       sid_data_oe;
    logic       reg_wr_stb;
    logic [4:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    int n_chk = 0;
    int n_bad = 0;

    int         c_stb_cnt;
    int         c_stb_lat;
    logic [4:0] c_stb_addr;
    logic [7:0] c_stb_data;
    int         c_oe_on;
    int         c_oe_off;
    logic [7:0] c_rd_data;
    logic       c_rd_ok;

    always #4 dcm_clk = ~dcm_clk;

    sid_bus_responder #(
        .SYNC_STAGES (2),
        .DECAY_CYCLES(4),
        .DECAY_W     (11)
    ) dut (
        .dcm_clk     (dcm_clk),
        .sid_notres  (sid_notres),
        .sid_clk     (sid_clk),
        .sid_notcs   (sid_notcs),
        .sid_rw      (sid_rw),
        .sid_addr    (sid_addr),
        .sid_data_in (sid_data_in),
        .pot_x       (pot_x),
        .pot_y       (pot_y),
        .osc3        (osc3),
        .env3        (env3),
        .sid_data_out(sid_data_out),
        .sid_data_oe (sid_data_oe),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_cycle(input logic cs_n, input logic rw, input logic [4:0] a, input logic [7:0] d);
        c_stb_cnt  = 0;
        c_stb_lat  = -1;
        c_stb_addr = 5'h00;
        c_stb_data = 8'h00;
        c_oe_on    = -1;
        c_oe_off   = -1;
        c_rd_data  = 8'h00;
        c_rd_ok    = 1'b1;
        @(negedge dcm_clk);
        sid_notcs   = cs_n;
        sid_rw      = rw;
        sid_addr    = a;
        sid_data_in = d;
        repeat (LOW_A) @(negedge dcm_clk);
        sid_clk = 1'b1;
        for (int i = 1; i <= HIGH; i++) begin
            @(negedge dcm_clk);
            if (sid_data_oe && c_oe_on < 0) begin
                c_oe_on   = i;
                c_rd_data = sid_data_out;
            end
            if (sid_data_oe && sid_data_out !== c_rd_data) c_rd_ok = 1'b0;
            if (reg_wr_stb) c_stb_cnt++;
        end
        sid_clk = 1'b0;
        for (int j = 1; j <= LOW_B; j++) begin
            @(negedge dcm_clk);
            if (c_oe_on >= 0 && !sid_data_oe && c_oe_off < 0) c_oe_off = j;
            if (sid_data_oe && sid_data_out !== c_rd_data) c_rd_ok = 1'b0;
            if (reg_wr_stb) begin
                if (c_stb_cnt == 0) begin
                    c_stb_lat  = j;
                    c_stb_addr = reg_wr_addr;
                    c_stb_data = reg_wr_data;
                end
                c_stb_cnt++;
            end
        end
    endtask

    task automatic do_write(input string tag, input logic [4:0] a, input logic [7:0] d, input logic exp_stb);
        bus_cycle(1'b0, 1'b0, a, d);
        check({tag, "_stb_cnt"}, c_stb_cnt, exp_stb ? 1 : 0);
        if (exp_stb) begin
            check({tag, "_stb_lat"}, c_stb_lat, 3);
            check({tag, "_addr"}, c_stb_addr, a);
            check({tag, "_data"}, c_stb_data, d);
        end
    endtask

    task automatic do_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
        bus_cycle(1'b0, 1'b1, a, 8'h00);
        check({tag, "_data"}, c_rd_data, exp);
        check({tag, "_oe_on"}, c_oe_on, 3);
    endtask

    initial begin
        int idle_stb;
        int idle_oe;
        int rst_stb;

        repeat (5) @(negedge dcm_clk);
        check("rst_stb", reg_wr_stb, 0);
        check("rst_oe", sid_data_oe, 0);
        check("rst_dout", sid_data_out, 8'h00);
        check("rst_waddr", reg_wr_addr, 5'h00);
        check("rst_wdata", reg_wr_data, 8'h00);
        sid_notres = 1'b1;

        idle_stb = 0;
        idle_oe  = 0;
        for (int k = 0; k < 10; k++) begin
            bus_cycle(1'b1, 1'b0, 5'h04, 8'hFF);
            idle_stb += c_stb_cnt;
            if (c_oe_on >= 0) idle_oe++;
        end
        check("idle_stb", idle_stb, 0);
        check("idle_oe", idle_oe, 0);
        check("idle_dout", sid_data_out, 8'h00);

        do_write("wr04", 5'h04, 8'h41, 1'b1);

        osc3 = 8'hA5;
        do_read("rd_osc3", 5'h1B, 8'hA5);
        check("rd_osc3_oe_off", c_oe_off, 3);
        check("rd_osc3_stable", c_rd_ok, 1'b1);
        do_read("rd_latch41", 5'h00, 8'h41);

        do_write("wr1D", 5'h1D, 8'h77, 1'b0);
        do_read("rd_latch77", 5'h05, 8'h77);

        do_write("wr_decay", 5'h1D, 8'h33, 1'b0);
        for (int k = 1; k <= 4; k++) do_read($sformatf("decay_rd%0d", k), 5'h10, 8'h33);
        do_read("decay_rd5", 5'h10, 8'h00);

        do_write("wr_rl", 5'h1E, 8'h33, 1'b0);
        for (int k = 1; k <= 3; k++) do_read($sformatf("reload_rd%0d", k), 5'h10, 8'h33);
        do_write("wr_rl4", 5'h1E, 8'h5A, 1'b0);
        for (int k = 5; k <= 8; k++) do_read($sformatf("reload_rd%0d", k), 5'h10, 8'h5A);
        do_read("reload_rd9", 5'h10, 8'h00);

        do_read("rd_potx", 5'h19, 8'h11);
        do_read("rd_poty", 5'h1A, 8'h22);
        do_read("rd_env3", 5'h1C, 8'h44);

        rst_stb = 0;
        @(negedge dcm_clk);
        sid_notcs   = 1'b0;
        sid_rw      = 1'b0;
        sid_addr    = 5'h0A;
        sid_data_in = 8'h99;
        repeat (LOW_A) @(negedge dcm_clk);
        sid_clk = 1'b1;
        repeat (40) @(negedge dcm_clk);
        sid_notres = 1'b0;
        @(negedge dcm_clk);
        check("mid_rst_oe", sid_data_oe, 0);
        check("mid_rst_dout", sid_data_out, 8'h00);
        check("mid_rst_waddr", reg_wr_addr, 5'h00);
        check("mid_rst_wdata", reg_wr_data, 8'h00);
        for (int k = 0; k < 88; k++) begin
            @(negedge dcm_clk);
            if (reg_wr_stb) rst_stb++;
        end
        sid_clk = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge dcm_clk);
            if (reg_wr_stb) rst_stb++;
        end
        sid_notres = 1'b1;
        for (int k = 0; k < 44; k++) begin
            @(negedge dcm_clk);
            if (reg_wr_stb) rst_stb++;
        end
        check("mid_rst_stb", rst_stb, 0);

        do_read("post_rst_latch", 5'h00, 8'h00);
        do_write("wr18", 5'h18, 8'hC3, 1'b1);
        do_write("wr19", 5'h19, 8'h5C, 1'b0);
        do_read("rd_latch5C", 5'h02, 8'h5C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
